// File: rtl/nios2_oci_dct_pkg.sv
// Shared types for the Nios II OCI DCT trace capture monitor: FSM states,
// entry layout and the stream entry width helper.
package nios2_oci_dct_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int DEF_DCT_W = 30;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_TS_W  = 16;

  // Entry layout at default widths; ts only present in timestamped builds.
  typedef struct packed {
    logic [DEF_TS_W-1:0]  ts;
    logic [DEF_CNT_W-1:0] count;
    logic [DEF_DCT_W-1:0] buffer;
  } entry_t;

  function automatic int entry_w(input int cnt_w, input int dct_w, input int ts_w,
                                 input bit ts_en);
    return cnt_w + dct_w + (ts_en ? ts_w : 0);
  endfunction

endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// Synchronous FIFO with registered first-word-fall-through read data,
// synchronous clear and full/empty/level status.
module nios2_oci_dct_fifo #(
  parameter  int W     = 34,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
    rdata_d  = rdata_q;
    // The head register must already hold the next entry when it becomes visible.
    if (do_push && ((level_q - LW'(do_pop)) == '0)) begin
      rdata_d = wdata_i;
    end else if (do_pop) begin
      rdata_d = mem_q[rd_ptr_d];
    end
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign level_o = level_q;

endmodule

// File: rtl/nios2_oci_dct_capture.sv
// Nios II OCI DCT trace capture monitor: qualifies trace frames into a FIFO
// and drains them over a stream. Optional DCT_CAPTURE_TIMESTAMP_EN prepends a timestamp.
module nios2_oci_dct_capture
  import nios2_oci_dct_pkg::*;
#(
  parameter int DCT_W = 30,
  parameter int CNT_W = 4,
  parameter int DEPTH = 16,
  parameter int OVF_W = 16,
  parameter int TS_W  = 16,
`ifdef DCT_CAPTURE_TIMESTAMP_EN
  localparam int ENTRY_W = entry_w(CNT_W, DCT_W, TS_W, 1'b1)
`else
  localparam int ENTRY_W = entry_w(CNT_W, DCT_W, TS_W, 1'b0)
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   capture_en,
  input  logic                   dct_valid,
  input  logic [DCT_W-1:0]       dct_buffer,
  input  logic [CNT_W-1:0]       dct_count,
  input  logic                   test_ending,
  input  logic                   test_has_ended,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ENTRY_W-1:0]     out_data,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow,
  output logic [OVF_W-1:0]       overflow_cnt,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  // Stream handshake: an entry transfers on a cycle with out_valid && out_ready;
  // out_data holds steady while out_valid is high and out_ready is low.

  state_e             state_q, state_d;
  logic               push_req, pop, drop;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] wdata;
  logic               overflow_q, overflow_d;
  logic [OVF_W-1:0]   ovf_cnt_q, ovf_cnt_d;

  assign push_req = (state_q == CAPTURE) && dct_valid && (dct_count != '0) && !test_has_ended;
  assign pop      = out_valid && out_ready;
  assign drop     = push_req && fifo_full && !pop;

`ifdef DCT_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end

  assign wdata = {ts_q, dct_count, dct_buffer};
`else
  assign wdata = {dct_count, dct_buffer};
`endif

  nios2_oci_dct_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (test_has_ended),
    .push_i  (push_req),
    .pop_i   (out_ready),
    .wdata_i (wdata),
    .rdata_o (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fill_level)
  );

  assign out_valid = !fifo_empty;

  always_comb begin
    state_d = state_q;
    if (test_has_ended) begin
      state_d = DONE;
    end else begin
      case (state_q)
        IDLE:    if (capture_en) state_d = CAPTURE;
        CAPTURE: begin
          if (test_ending)      state_d = FLUSH;
          else if (!capture_en) state_d = IDLE;
        end
        FLUSH:   if (fifo_empty) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign overflow     = overflow_q;
  assign overflow_cnt = ovf_cnt_q;
  assign done         = (state_q == DONE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Self-checking bench for nios2_oci_dct_capture (default parameters); also
// builds with DCT_CAPTURE_TIMESTAMP_EN, where timestamp ordering is checked.
module tb_nios2_oci_dct_capture;

  localparam int CD_W = 34;
`ifdef DCT_CAPTURE_TIMESTAMP_EN
  localparam int EW = 50;
`else
  localparam int EW = 34;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          capture_en, dct_valid, test_ending, test_has_ended, out_ready;
  logic [29:0]   dct_buffer;
  logic [3:0]    dct_count;
  logic          out_valid, overflow, done;
  logic [EW-1:0] out_data;
  logic [4:0]    fill_level;
  logic [15:0]   overflow_cnt;
  logic [1:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nios2_oci_dct_capture dut (
    .clk            (clk),
    .reset          (reset),
    .capture_en     (capture_en),
    .dct_valid      (dct_valid),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .overflow_cnt   (overflow_cnt),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  // Records each accepted stream entry, then advances one clock.
  task automatic tick();
    if (out_valid && out_ready) obs_q.push_back(out_data);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; capture_en = 1'b0; dct_valid = 1'b0; dct_buffer = '0; dct_count = '0;
    test_ending = 1'b0; test_has_ended = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic send(input logic [29:0] b, input logic [3:0] c, input bit expect_push);
    dct_valid = 1'b1; dct_buffer = b; dct_count = c;
    if (expect_push) exp_q.push_back(EW'({c, b}));
    tick();
    dct_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL reset_fill_level: got %0d want 0", fill_level); end
    n_checks++; if (overflow !== 1'b0 || overflow_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_overflow: got %b/%0d want 0/0", overflow, overflow_cnt); end
    n_checks++; if (done !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: done=%b state=%0d want 0/0", done, dbg_state); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
  endtask

  task automatic test_in_order();
    logic [29:0] bufs[3] = '{30'h1, 30'h2, 30'h3};
    logic [3:0]  cnts[3] = '{4'd3, 4'd4, 4'd1};
    logic [EW-1:0] e, o;
    do_reset();
    capture_en = 1'b1; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      dct_valid = 1'b1; dct_buffer = bufs[i]; dct_count = cnts[i];
      e = EW'({cnts[i], bufs[i]});
      exp_q.push_back(e);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data[CD_W-1:0] !== e[CD_W-1:0]) begin
        n_fail++; $display("FAIL in_order_latency[%0d]: valid=%b data=%h want valid=1 data=%h", i, out_valid, out_data[CD_W-1:0], e[CD_W-1:0]);
      end
    end
    dct_valid = 1'b0;
    tick();
    send(30'h3ff, 4'd0, 1'b0);
    tick();
    n_checks++; if (fill_level !== 5'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_frame_ignored: level=%0d valid=%b want 0/0", fill_level, out_valid); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL in_order_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o[CD_W-1:0] !== e[CD_W-1:0]) begin n_fail++; $display("FAIL in_order_data: got %h want %h", o[CD_W-1:0], e[CD_W-1:0]); end
    end
  endtask

  task automatic test_overflow_and_full_push_pop();
    logic [EW-1:0] e, o;
    do_reset();
    capture_en = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) send(30'h100 + 30'(i), 4'((i % 15) + 1), i < 16);
    n_checks++; if (fill_level !== 5'd16) begin n_fail++; $display("FAIL overflow_fill: got %0d want 16", fill_level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_flag: got %b want 1", overflow); end
    n_checks++; if (overflow_cnt !== 16'd4) begin n_fail++; $display("FAIL overflow_cnt: got %0d want 4", overflow_cnt); end
    out_ready = 1'b1;
    send(30'h200, 4'd5, 1'b1);
    n_checks++; if (fill_level !== 5'd16) begin n_fail++; $display("FAIL full_push_pop_fill: got %0d want 16", fill_level); end
    n_checks++; if (overflow_cnt !== 16'd4) begin n_fail++; $display("FAIL full_push_pop_cnt: got %0d want 4", overflow_cnt); end
    for (int k = 0; k < 40 && fill_level != 0; k++) tick();
    n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL overflow_drain_timeout: level=%0d want 0", fill_level); end
    n_checks++; if (obs_q.size() != 17) begin n_fail++; $display("FAIL overflow_count: got %0d want 17", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o[CD_W-1:0] !== e[CD_W-1:0]) begin n_fail++; $display("FAIL overflow_data: got %h want %h", o[CD_W-1:0], e[CD_W-1:0]); end
    end
  endtask

  task automatic test_test_ending();
    logic [EW-1:0] e, o;
`ifdef DCT_CAPTURE_TIMESTAMP_EN
    logic [15:0] prev_ts = '0;
    bit first = 1'b1;
`endif
    do_reset();
    capture_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      test_ending = (i == 4);
      send(30'($urandom_range(0, 32'h3fff_ffff)), 4'($urandom_range(1, 15)), 1'b1);
    end
    test_ending = 1'b0;
    send(30'h155, 4'd2, 1'b0);
    n_checks++; if (fill_level !== 5'd5 || dbg_state !== 2'd2) begin n_fail++; $display("FAIL ending_hold: level=%0d state=%0d want 5/2", fill_level, dbg_state); end
    out_ready = 1'b1;
    for (int k = 0; k < 40 && fill_level != 0; k++) tick();
    n_checks++; if (fill_level !== 5'd0 || done !== 1'b0) begin n_fail++; $display("FAIL ending_empty: level=%0d done=%b want 0/0", fill_level, done); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ending_done: got %b want 1", done); end
    n_checks++; if (obs_q.size() != 5) begin n_fail++; $display("FAIL ending_count: got %0d want 5", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o[CD_W-1:0] !== e[CD_W-1:0]) begin n_fail++; $display("FAIL ending_data: got %h want %h", o[CD_W-1:0], e[CD_W-1:0]); end
`ifdef DCT_CAPTURE_TIMESTAMP_EN
      if (!first) begin
        n_checks++; if (o[EW-1:CD_W] <= prev_ts) begin n_fail++; $display("FAIL ts_order: got %0d after %0d", o[EW-1:CD_W], prev_ts); end
      end
      prev_ts = o[EW-1:CD_W]; first = 1'b0;
`endif
    end
  endtask

  task automatic test_has_ended_abort();
    do_reset();
    capture_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) send(30'h40 + 30'(i), 4'd7, 1'b1);
    test_has_ended = 1'b1; test_ending = 1'b1;
    tick();
    test_has_ended = 1'b0; test_ending = 1'b0;
    n_checks++; if (fill_level !== 5'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_clear: level=%0d valid=%b want 0/0", fill_level, out_valid); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL abort_done: got %b want 1", done); end
    send(30'h77, 4'd3, 1'b0);
    tick();
    n_checks++; if (done !== 1'b1 || fill_level !== 5'd0) begin n_fail++; $display("FAIL done_terminal: done=%b level=%0d want 1/0", done, fill_level); end
    exp_q.delete();
  endtask

  task automatic test_idle_keeps_and_reset_mid_drain();
    do_reset();
    capture_en = 1'b1;
    tick();
    send(30'h11, 4'd1, 1'b1);
    send(30'h22, 4'd2, 1'b1);
    capture_en = 1'b0;
    tick();
    n_checks++; if (dbg_state !== 2'd0 || fill_level !== 5'd2) begin n_fail++; $display("FAIL idle_keeps: state=%0d level=%0d want 0/2", dbg_state, fill_level); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (obs_q.size() != 1 || obs_q[0][CD_W-1:0] !== exp_q[0][CD_W-1:0]) begin n_fail++; $display("FAIL idle_drain: n=%0d want 1 entry %h", obs_q.size(), exp_q[0][CD_W-1:0]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (fill_level !== 5'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_drain: level=%0d valid=%b want 0/0", fill_level, out_valid); end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_overflow_and_full_push_pop();
    test_test_ending();
    test_has_ended_abort();
    test_idle_keeps_and_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
